rotfpga_scan_loader: RTL
========================

# rotfpga_scan_loader

Configuration loader that sits directly upstream of the rotatable-tile FPGA core's scan chain. It accepts configuration bytes over a valid/ready stream and serialises them LSB-first onto the scan-enable / scan-data pins for exactly CHAIN_LEN bits. It simultaneously captures the bits shifted out of the chain's scan output, returning them as readback bytes. A full load is therefore also a non-destructive-readable dump of the previous configuration.

## Interface

- CHAIN_LEN, 512: total scan-chain length in bits (≥1; need not be a multiple of 8)
- CNT_W, 10: bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN

- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE, no done pulse
- in_data  in  8  configuration byte, bit 0 shifted first
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- scan_en  out  1  scan enable to core (uio_in[0] of the core)
- scan_do  out  1  serial data into core chain (uio_in[1])
- scan_di  in  1  serial data from core chain (uio_out[7])
- rb_data  out  8  readback byte, bit i = i-th bit captured in that byte
- rb_valid  out  1  one-cycle strobe, rb_data valid
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle strobe at completion of CHAIN_LEN bits

## Operation

- States: IDLE, LOAD, SHIFT.
- IDLE: in_ready=0, scan_en=0. start=1 → LOAD; bit counter cleared.
- LOAD: in_ready=1. in_valid&in_ready → latch in_data into tx shift register, clear rx byte register, → SHIFT. No time-out; the loader waits indefinitely.
- SHIFT: one bit per cycle. scan_en=1, scan_do=tx[k] for byte-local index k=0..7. On each SHIFT edge: rx[k] ← scan_di; bit counter +1.
- Byte ends after 8 bits or when the counter reaches CHAIN_LEN, whichever comes first.
  - Byte end, not chain end: rb_valid pulse, → LOAD.
  - Chain end: rb_valid and done pulse together, → IDLE.
- Partial final byte (CHAIN_LEN mod 8 = m ≠ 0): only m bits are shifted. The upper 8−m bits of that input byte are discarded. rb_data[7:m]=0.
- Bytes needed per load: ceil(CHAIN_LEN/8).
- abort=1 in any state → IDLE next edge. scan_en=0 from that edge on, no rb_valid, no done. abort has priority over every other event.
- start while busy is ignored. start and abort together in IDLE: stay IDLE.
- rb_valid has no back-pressure; the consumer must take rb_data in the strobe cycle.
- scan_do=0 whenever scan_en=0.

## Timing

- Reset (asynchronous assert): state IDLE; in_ready, scan_en, scan_do, rb_valid, busy, done = 0; rb_data = 0; counters = 0.
- Reset asserted mid-shift: scan_en drops immediately, without waiting for a clock edge. The core chain is left partially shifted; this is acceptable.
- All outputs are registered except in_ready and busy, which decode state combinationally from registered state.
- start sampled at edge t → in_ready=1 from t+1.
- Byte accepted at edge e → scan_en=1 during cycles e+1..e+8. Core shifts on edges e+1..e+8. scan_di is sampled on those same edges.
- rb_valid (and done, if last) high for the cycle following edge e+8, i.e. in the first cycle back in LOAD or IDLE. For a partial byte, substitute m for 8.
- Minimum cost is 9 cycles per full byte (1 accept + 8 shift). Back-to-back bytes add no further bubble; in_ready is high in the same cycle as rb_valid.
- Full load minimum: 9·ceil(CHAIN_LEN/8) cycles, adjusted for a partial last byte, after the start edge plus 1.

## Test plan

Benches run with CHAIN_LEN=20 and a behavioural 20-bit scan-chain model, preloaded.

- Reset: assert rst_n=0 mid-SHIFT → scan_en, rb_valid, done, in_ready = 0 with no clock edge; after release, busy=0.
- Full load: preload chain 0xABCDE; start; feed 0x12, 0x34, 0x56.
  - rb_data sequence = 0xDE, 0xBC, 0x0A (last byte 4 bits).
  - Chain afterwards = 0x63412; upper nibble 0x5 discarded.
  - done coincides with the third rb_valid.
  - Exactly 20 cycles with scan_en=1.
- Back-pressure: in_valid held low for 10 cycles in LOAD → scan_en stays 0, chain unchanged, in_ready stays 1.
- Cycle timing: byte accepted at edge e → scan_en first high in cycle e+1, rb_valid in cycle e+9. With in_valid held high, the next byte is accepted in the same cycle as rb_valid.
- Abort: abort after the 3rd shift bit of byte 2 → IDLE next edge, no done, no further rb_valid, busy=0. A subsequent full load completes normally.
- Ignored events: start pulsed during SHIFT → no effect on counters; start+abort together in IDLE → stays IDLE.

Source files
------------

// File: rtl/rotfpga_scan_loader.sv
// -----------------------------------------------------------------------------
// rotfpga_scan_loader
//
// Purpose
//   Streams configuration bytes into the rotatable-tile FPGA core's scan
//   chain, LSB first, for exactly CHAIN_LEN bits. While it shifts, it captures
//   the bits leaving the chain and returns them as readback bytes. A full load
//   therefore also dumps the previous configuration.
//
//   Each byte costs one accept cycle plus up to eight shift cycles. When
//   CHAIN_LEN is not a multiple of 8, only the low CHAIN_LEN mod 8 bits of the
//   last byte are shifted. The unused upper bits of that readback byte read 0.
//
// Parameters
//   CHAIN_LEN  total scan-chain length in bits (>= 1)
//   CNT_W      bit-counter width, 2**CNT_W > CHAIN_LEN
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a load (sampled only while idle)
//   abort     in   synchronous abort, highest priority
//   in_data   in   configuration byte, bit 0 shifted first
//   in_valid  in   in_data valid
//   in_ready  out  loader accepts a byte this cycle (decoded from state)
//   scan_en   out  scan enable to the core
//   scan_do   out  serial data into the core chain
//   scan_di   in   serial data out of the core chain
//   rb_data   out  readback byte, bit i = i-th bit captured in that byte
//   rb_valid  out  one-cycle strobe qualifying rb_data (no back-pressure)
//   busy      out  high in every state except idle (decoded from state)
//   done      out  one-cycle strobe when the last chain bit has been shifted
// -----------------------------------------------------------------------------
module rotfpga_scan_loader #(
    parameter int CHAIN_LEN = 512,
    parameter int CNT_W     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       scan_en,
    output logic       scan_do,
    input  logic       scan_di,
    output logic [7:0] rb_data,
    output logic       rb_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    // Counter value held while the final chain bit is on the pins.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;      // bits shifted so far in this load
    logic [2:0]       bit_q,      bit_d;      // byte-local bit index k
    logic [7:0]       tx_q,       tx_d;       // byte being shifted out
    logic [7:0]       rx_q,       rx_d;       // bits captured for this byte
    logic             scan_en_q,  scan_en_d;
    logic             scan_do_q,  scan_do_d;
    logic [7:0]       rb_data_q,  rb_data_d;
    logic             rb_valid_q, rb_valid_d;
    logic             done_q,     done_d;

    // Helper terms for the SHIFT state.
    logic       chain_end;
    logic       byte_end;
    logic [2:0] bit_nxt;
    logic [7:0] rx_cap;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // Reset is asynchronous on every register. This lets scan_en drop as soon
    // as rst_n falls, even in the middle of a shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            scan_en_q  <= 1'b0;
            scan_do_q  <= 1'b0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            scan_en_q  <= scan_en_d;
            scan_do_q  <= scan_do_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
            done_q     <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        scan_en_d  = 1'b0;
        scan_do_d  = 1'b0;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        done_d     = 1'b0;

        // A byte ends after bit 7, or earlier when it is the last chain bit.
        chain_end = (cnt_q == LAST_BIT);
        byte_end  = (bit_q == 3'd7) || chain_end;
        bit_nxt   = bit_q + 3'd1;

        // rx_q is cleared when a byte is accepted, so bits past a partial
        // last byte stay 0 in the readback.
        rx_cap         = rx_q;
        rx_cap[bit_q]  = scan_di;

        if (abort) begin
            // Abort beats everything else. The defaults drop scan_en/scan_do
            // and suppress rb_valid and done.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end
                end

                S_LOAD: begin
                    // in_ready is high for the whole of LOAD. Accepting a byte
                    // drives its bit 0 onto the pins for the first shift edge.
                    if (in_valid) begin
                        tx_d      = in_data;
                        rx_d      = '0;
                        bit_d     = '0;
                        scan_en_d = 1'b1;
                        scan_do_d = in_data[0];
                        state_d   = S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    // The core shifts on this edge, and scan_di is sampled on
                    // the same edge.
                    rx_d  = rx_cap;
                    cnt_d = cnt_q + 1'b1;
                    bit_d = bit_nxt;
                    if (byte_end) begin
                        rb_valid_d = 1'b1;
                        rb_data_d  = rx_cap;
                        if (chain_end) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        scan_en_d = 1'b1;
                        scan_do_d = tx_q[bit_nxt];
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // scan_do_d is forced to 0 whenever scan_en_d is 0, so scan_do is low
    // whenever the chain is not enabled.
    assign scan_en  = scan_en_q;
    assign scan_do  = scan_do_q;
    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
    assign done     = done_q;

    // Handshake and status are decoded from the registered state.
    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);

endmodule
